// File: rtl/yi_writer_pkg.sv
// Shared definitions for the Yi result writer.
//   - FSM state encoding
//   - AXI4 burst / size / response constants
//   - Yi word geometry (one Yi word = one 64-bit AXI beat)
package yi_writer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam int          ADDR_W          = 48;
    localparam int          YI_WORD_BYTES   = 8;

    localparam logic [1:0]  AXI_BURST_INCR  = 2'b01;
    localparam logic [2:0]  AXI_SIZE_8B     = 3'd3;   // log2(YI_WORD_BYTES)

    localparam logic [1:0]  AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0]  AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0]  AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0]  AXI_RESP_DECERR = 2'b11;

endpackage

// File: rtl/yi_writer.sv
// yi_writer -- streams a job of 64-bit Yi words to memory over AXI4 write.
//
// A job starts with a one-cycle Write_Begin pulse carrying Write_Length (in
// words). Words are written to consecutive addresses starting at
// YVal_BASE_ADDR, split into INCR bursts of at most MAX_BURST beats. Only one
// burst is in flight at a time: AW, then all W beats, then wait for B.
//
// Ports
//   clk, rstn                 clock, asynchronous active-low reset
//   Write_Begin/Write_Length  job start pulse and word count
//   input_valid/ready/data    incoming Yi word stream
//   m_axi_Yi_aw*              AXI4 write address channel
//   m_axi_Yi_w*               AXI4 write data channel
//   m_axi_Yi_b*               AXI4 write response channel
//   Write_Busy                high while a job is in progress
//   Write_Done                one-cycle pulse when a job completes
//   Write_Error               sticky error flag
//
// Build option
//   YI_WRITER_BRESP_CHECK_EN  when defined, a non-OKAY bresp sets Write_Error
//                             (the job still runs to completion); when
//                             undefined, bresp is ignored and Write_Error = 0.
module yi_writer
    import yi_writer_pkg::*;
#(
    parameter logic [31:0] YVal_BASE_ADDR = 32'h40000000,
    parameter int          MAX_BURST      = 16
) (
    input  logic        clk,
    input  logic        rstn,

    input  logic        Write_Begin,
    input  logic [31:0] Write_Length,

    input  logic        input_valid,
    output logic        input_ready,
    input  logic [63:0] input_data,

    output logic        m_axi_Yi_awid,
    output logic [47:0] m_axi_Yi_awaddr,
    output logic [7:0]  m_axi_Yi_awlen,
    output logic [2:0]  m_axi_Yi_awsize,
    output logic [1:0]  m_axi_Yi_awburst,
    output logic        m_axi_Yi_awvalid,
    input  logic        m_axi_Yi_awready,

    output logic [63:0] m_axi_Yi_wdata,
    output logic [7:0]  m_axi_Yi_wstrb,
    output logic        m_axi_Yi_wlast,
    output logic        m_axi_Yi_wvalid,
    input  logic        m_axi_Yi_wready,

    input  logic        m_axi_Yi_bid,
    input  logic [1:0]  m_axi_Yi_bresp,
    input  logic        m_axi_Yi_bvalid,
    output logic        m_axi_Yi_bready,

    output logic        Write_Busy,
    output logic        Write_Done,
    output logic        Write_Error
);

    localparam logic [31:0] MAX_BURST_W = 32'(MAX_BURST);

    state_t              state_q, state_d;
    logic [31:0]         remaining_q;
    logic [ADDR_W-1:0]   address_q;
    logic [7:0]          beat_q;
    logic                done_q;

    logic [8:0]          burst_beats;
    logic [8:0]          burst_len_m1;
    logic [31:0]         remaining_after;
    logic [ADDR_W-1:0]   burst_bytes;
    logic                beat_fire;
    logic                last_beat;
    logic                b_fire;

    // Size of the current burst. remaining_q is constant from ADDR through
    // RESP, so awlen and the RESP-time bookkeeping see the same value.
    always_comb begin
        burst_beats = 9'(MAX_BURST);
        if (remaining_q < MAX_BURST_W)
            burst_beats = remaining_q[8:0];
    end

    assign burst_len_m1    = burst_beats - 9'd1;
    assign remaining_after = remaining_q - 32'(burst_beats);
    assign burst_bytes     = ADDR_W'(burst_beats) * ADDR_W'(YI_WORD_BYTES);

    assign beat_fire = (state_q == DATA) && input_valid && m_axi_Yi_wready;
    assign last_beat = (beat_q == burst_len_m1[7:0]);
    assign b_fire    = (state_q == RESP) && m_axi_Yi_bvalid;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (Write_Begin && (Write_Length != 32'd0)) state_d = ADDR;
            ADDR: if (m_axi_Yi_awready)                       state_d = DATA;
            DATA: if (beat_fire && last_beat)                 state_d = RESP;
            RESP: if (m_axi_Yi_bvalid)
                      state_d = (remaining_after != 32'd0) ? ADDR : IDLE;
            default:                                          state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------- job tracking
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            remaining_q <= '0;
            address_q   <= '0;
            beat_q      <= '0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (Write_Begin) begin
                    remaining_q <= Write_Length;
                    address_q   <= ADDR_W'(YVal_BASE_ADDR);
                    beat_q      <= '0;
                    // Zero-length jobs complete immediately.
                    done_q      <= (Write_Length == 32'd0);
                end
                DATA: if (beat_fire)
                    beat_q <= last_beat ? 8'd0 : beat_q + 8'd1;
                RESP: if (b_fire) begin
                    remaining_q <= remaining_after;
                    address_q   <= address_q + burst_bytes;
                    done_q      <= (remaining_after == 32'd0);
                end
                default: ;
            endcase
        end
    end

    // --------------------------------------------------------- error flag
`ifdef YI_WRITER_BRESP_CHECK_EN
    logic err_q;
    logic unused_bid;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            err_q <= 1'b0;
        else if ((state_q == IDLE) && Write_Begin)
            err_q <= 1'b0;
        else if (b_fire && (m_axi_Yi_bresp != AXI_RESP_OKAY))
            err_q <= 1'b1;
    end

    assign Write_Error = err_q;
    assign unused_bid  = m_axi_Yi_bid;
`else
    logic unused_b_inputs;
    assign Write_Error     = 1'b0;
    assign unused_b_inputs = ^{m_axi_Yi_bid, m_axi_Yi_bresp};
`endif

    // ------------------------------------------------------------ outputs
    // AW fields come from registers only, so they are stable under stall.
    assign m_axi_Yi_awid    = 1'b0;
    assign m_axi_Yi_awaddr  = address_q;
    assign m_axi_Yi_awlen   = burst_len_m1[7:0];
    assign m_axi_Yi_awsize  = AXI_SIZE_8B;
    assign m_axi_Yi_awburst = AXI_BURST_INCR;
    assign m_axi_Yi_awvalid = (state_q == ADDR);

    // W is a straight pass-through of the input stream while in DATA; the
    // upstream holds its data while stalled, and wlast only moves on a beat.
    assign m_axi_Yi_wdata   = input_data;
    assign m_axi_Yi_wstrb   = 8'hFF;
    assign m_axi_Yi_wvalid  = (state_q == DATA) && input_valid;
    assign m_axi_Yi_wlast   = (state_q == DATA) && last_beat;
    assign input_ready      = (state_q == DATA) && m_axi_Yi_wready;

    assign m_axi_Yi_bready  = (state_q == RESP);

    assign Write_Busy       = (state_q != IDLE);
    assign Write_Done       = done_q;

endmodule
